// File: rtl/tdm_ingress_mux.sv
// tdm_ingress_mux: per-port byte FIFOs serialised onto one TDM byte lane.
// Optional `INGRESS_STATS_EN adds per-port packet counters and a read port.
module tdm_ingress_mux #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_PORTS  = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int SLOT_BITS  = 8,
    localparam int PORT_BITS = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            in_valid,
    input  logic [NUM_PORTS-1:0]            in_new_packet,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
    output logic [NUM_PORTS-1:0]            in_ready,
    output logic                            output_wire,
    output logic                            output_new_packet,
    output logic [DATA_WIDTH-1:0]           output_data,
    output logic [SLOT_BITS-1:0]            slot_out,
    output logic [NUM_PORTS-1:0]            err_overflow
`ifdef INGRESS_STATS_EN
    ,
    input  logic [PORT_BITS-1:0]            stat_port,
    output logic [15:0]                     stat_pkts
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = DATA_WIDTH + 1;

    typedef logic [ENT_W-1:0] entry_t;

    logic [SLOT_BITS-1:0]  slot_q, slot_d;
    entry_t                mem_q [NUM_PORTS][FIFO_DEPTH];
    entry_t                mem_d [NUM_PORTS][FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q [NUM_PORTS];
    logic [PTR_W-1:0]      wr_ptr_d [NUM_PORTS];
    logic [PTR_W-1:0]      rd_ptr_q [NUM_PORTS];
    logic [PTR_W-1:0]      rd_ptr_d [NUM_PORTS];
    logic [CNT_W-1:0]      count_q  [NUM_PORTS];
    logic [CNT_W-1:0]      count_d  [NUM_PORTS];
    logic [NUM_PORTS-1:0]  err_q, err_d;
    logic                  wire_q, wire_d;
    logic                  newpkt_q, newpkt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic [NUM_PORTS-1:0]  full;
    logic [NUM_PORTS-1:0]  push;
    logic [NUM_PORTS-1:0]  pop;
    entry_t                head [NUM_PORTS];

    // Full/push/pop decode; a port pops on the edge entering its own slot.
    always_comb begin
        slot_d = slot_q + 1'b1;
        for (int p = 0; p < NUM_PORTS; p++) begin
            full[p] = (count_q[p] == CNT_W'(FIFO_DEPTH));
            push[p] = in_valid[p] && !full[p];
            pop[p]  = (slot_d == SLOT_BITS'(p)) && (count_q[p] != '0);
            head[p] = mem_q[p][rd_ptr_q[p]];
        end
    end

    // FIFO storage, pointers, counts and sticky overflow flags.
    always_comb begin
        mem_d = mem_q;
        err_d = err_q | (in_valid & full);
        for (int p = 0; p < NUM_PORTS; p++) begin
            wr_ptr_d[p] = wr_ptr_q[p] + PTR_W'(push[p]);
            rd_ptr_d[p] = rd_ptr_q[p] + PTR_W'(pop[p]);
            count_d[p]  = count_q[p] + CNT_W'(push[p]) - CNT_W'(pop[p]);
            if (push[p]) begin
                mem_d[p][wr_ptr_q[p]] = {in_new_packet[p],
                                         in_data[p*DATA_WIDTH +: DATA_WIDTH]};
            end
        end
    end

    // Lane prefetch: register the popped head, or an all-zero idle beat.
    always_comb begin
        wire_d   = 1'b0;
        newpkt_d = 1'b0;
        data_d   = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (pop[p]) begin
                wire_d   = 1'b1;
                newpkt_d = head[p][DATA_WIDTH];
                data_d   = head[p][DATA_WIDTH-1:0];
            end
        end
    end

    // Data storage needs no reset; validity is tracked by the counts.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control state and lane registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_q   <= '0;
            err_q    <= '0;
            wire_q   <= 1'b0;
            newpkt_q <= 1'b0;
            data_q   <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                wr_ptr_q[p] <= '0;
                rd_ptr_q[p] <= '0;
                count_q[p]  <= '0;
            end
        end else begin
            slot_q   <= slot_d;
            err_q    <= err_d;
            wire_q   <= wire_d;
            newpkt_q <= newpkt_d;
            data_q   <= data_d;
            for (int p = 0; p < NUM_PORTS; p++) begin
                wr_ptr_q[p] <= wr_ptr_d[p];
                rd_ptr_q[p] <= rd_ptr_d[p];
                count_q[p]  <= count_d[p];
            end
        end
    end

    // Ready looks only at the registered count, never at a same-cycle pop.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            in_ready[p] = !full[p];
        end
    end

    assign output_wire       = wire_q;
    assign output_new_packet = newpkt_q;
    assign output_data       = data_q;
    assign slot_out          = slot_q;
    assign err_overflow      = err_q;

`ifdef INGRESS_STATS_EN
    logic [15:0] pkt_cnt_q [NUM_PORTS];
    logic [15:0] pkt_cnt_d [NUM_PORTS];
    logic [15:0] stat_q, stat_d;

    // Saturating count of packet-start bytes leaving each port.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            pkt_cnt_d[p] = pkt_cnt_q[p];
            if (pop[p] && head[p][DATA_WIDTH] && pkt_cnt_q[p] != 16'hFFFF) begin
                pkt_cnt_d[p] = pkt_cnt_q[p] + 16'd1;
            end
        end
        stat_d = pkt_cnt_q[stat_port];
    end

    // Counter state and the one-cycle-latency read register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_q <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                pkt_cnt_q[p] <= '0;
            end
        end else begin
            stat_q <= stat_d;
            for (int p = 0; p < NUM_PORTS; p++) begin
                pkt_cnt_q[p] <= pkt_cnt_d[p];
            end
        end
    end

    assign stat_pkts = stat_q;
`endif

endmodule

// File: tb/tb_tdm_ingress_mux.sv
// tb_tdm_ingress_mux: directed checks of the TDM ingress mux.
// Define INGRESS_STATS_EN to also exercise the packet counters.
module tb_tdm_ingress_mux;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [15:0]  in_valid = '0;
    logic [15:0]  in_new_packet = '0;
    logic [127:0] in_data = '0;
    logic [15:0]  in_ready;
    logic         output_wire;
    logic         output_new_packet;
    logic [7:0]   output_data;
    logic [7:0]   slot_out;
    logic [15:0]  err_overflow;
`ifdef INGRESS_STATS_EN
    logic [3:0]   stat_port = '0;
    logic [15:0]  stat_pkts;
`endif

    int vectors = 0;
    int errors  = 0;

    tdm_ingress_mux dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_new_packet     (in_new_packet),
        .in_data           (in_data),
        .in_ready          (in_ready),
        .output_wire       (output_wire),
        .output_new_packet (output_new_packet),
        .output_data       (output_data),
        .slot_out          (slot_out),
        .err_overflow      (err_overflow)
`ifdef INGRESS_STATS_EN
        ,
        .stat_port         (stat_port),
        .stat_pkts         (stat_pkts)
`endif
    );

    always #5 clk = ~clk;

    // Advance on falling edges until slot_out equals t, bounded to 300 cycles.
    task automatic wait_slot(input logic [7:0] t);
        int n;
        n = 0;
        while (slot_out !== t && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (slot_out !== t) begin
            vectors++;
            errors++;
            $display("FAIL wait_slot: slot_out=%0d never reached %0d", slot_out, t);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        vectors++;
        if ({output_wire, output_new_packet, output_data} !== 10'h0) begin
            errors++;
            $display("FAIL reset_lane: got %b/%b/%h want 0/0/00",
                     output_wire, output_new_packet, output_data);
        end
        vectors++;
        if (slot_out !== 8'd0) begin
            errors++;
            $display("FAIL reset_slot: got %0d want 0", slot_out);
        end
        vectors++;
        if (in_ready !== 16'hFFFF) begin
            errors++;
            $display("FAIL reset_ready: got %h want ffff", in_ready);
        end
        vectors++;
        if (err_overflow !== 16'h0) begin
            errors++;
            $display("FAIL reset_err: got %h want 0000", err_overflow);
        end
        rst = 1'b1;
    endtask

    // Three bytes on port 3, one per slot-3 visit; every other slot idle.
    task automatic test_single_port;
        logic [7:0] bytes [3];
        logic       flags [3];
        int         k;
        bytes = '{8'hA1, 8'hA2, 8'hA3};
        flags = '{1'b1, 1'b0, 1'b0};
        vectors++;
        if (slot_out !== 8'd0 || output_wire !== 1'b0) begin
            errors++;
            $display("FAIL first_slot_idle: slot %0d wire %b want 0 0",
                     slot_out, output_wire);
        end
        for (int i = 0; i < 3; i++) begin
            in_valid[3]      = 1'b1;
            in_new_packet[3] = flags[i];
            in_data[24 +: 8] = bytes[i];
            @(negedge clk);
        end
        in_valid = '0;
        in_new_packet = '0;
        in_data = '0;
        k = 0;
        for (int c = 0; c < 768; c++) begin
            vectors++;
            if (slot_out == 8'd3 && k < 3) begin
                if ({output_wire, output_new_packet, output_data} !==
                    {1'b1, flags[k], bytes[k]}) begin
                    errors++;
                    $display("FAIL port3_byte%0d: got %b/%b/%h want 1/%b/%h",
                             k, output_wire, output_new_packet, output_data,
                             flags[k], bytes[k]);
                end
                k++;
            end else if ({output_wire, output_new_packet, output_data} !== 10'h0) begin
                errors++;
                $display("FAIL port3_idle slot %0d: got %b/%b/%h want 0/0/00",
                         slot_out, output_wire, output_new_packet, output_data);
            end
            @(negedge clk);
        end
        vectors++;
        if (k != 3) begin
            errors++;
            $display("FAIL port3_count: saw %0d slot-3 beats want 3", k);
        end
    endtask

    // Seventeen bytes into port 0 with no intervening pop.
    task automatic test_overflow;
        wait_slot(8'd100);
        for (int i = 1; i <= 17; i++) begin
            in_valid[0]      = 1'b1;
            in_new_packet[0] = (i == 1);
            in_data[7:0]     = 8'(i);
            @(negedge clk);
            if (i == 15) begin
                vectors++;
                if (in_ready[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL ovf_ready15: got %b want 1", in_ready[0]);
                end
            end
            if (i == 16) begin
                vectors++;
                if (in_ready[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_ready16: got %b want 0", in_ready[0]);
                end
            end
        end
        in_valid = '0;
        in_new_packet = '0;
        in_data = '0;
        vectors++;
        if (err_overflow !== 16'h0001) begin
            errors++;
            $display("FAIL ovf_err: got %h want 0001", err_overflow);
        end
        for (int k = 0; k < 16; k++) begin
            wait_slot(8'd0);
            vectors++;
            if ({output_wire, output_new_packet, output_data} !==
                {1'b1, (k == 0), 8'(k + 1)}) begin
                errors++;
                $display("FAIL ovf_drain%0d: got %b/%b/%h want 1/%b/%h", k,
                         output_wire, output_new_packet, output_data,
                         (k == 0), 8'(k + 1));
            end
            @(negedge clk);
        end
        wait_slot(8'd0);
        vectors++;
        if (output_wire !== 1'b0) begin
            errors++;
            $display("FAIL ovf_dropped: got wire %b data %h want 0", output_wire, output_data);
        end
        vectors++;
        if (err_overflow[0] !== 1'b1 || in_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: err %b ready %b want 1 1",
                     err_overflow[0], in_ready[0]);
        end
        @(negedge clk);
    endtask

    // One byte on every port in slot 20; they leave in slots 0..15.
    task automatic test_all_ports;
        wait_slot(8'd20);
        in_valid      = 16'hFFFF;
        in_new_packet = 16'hAAAA;
        for (int p = 0; p < 16; p++) in_data[p*8 +: 8] = 8'(8'h30 + p);
        @(negedge clk);
        in_valid = '0;
        in_new_packet = '0;
        in_data = '0;
        wait_slot(8'd0);
        for (int c = 0; c < 256; c++) begin
            vectors++;
            if (c < 16) begin
                if ({output_wire, output_new_packet, output_data} !==
                    {1'b1, (c % 2 == 1), 8'(8'h30 + c)} || slot_out !== 8'(c)) begin
                    errors++;
                    $display("FAIL all_ports slot %0d: got %0d %b/%b/%h want 1/%b/%h",
                             c, slot_out, output_wire, output_new_packet, output_data,
                             (c % 2 == 1), 8'(8'h30 + c));
                end
            end else if ({output_wire, output_new_packet, output_data} !== 10'h0 ||
                         slot_out !== 8'(c)) begin
                errors++;
                $display("FAIL all_idle slot %0d: got %0d %b/%b/%h want 0/0/00",
                         c, slot_out, output_wire, output_new_packet, output_data);
            end
            @(negedge clk);
        end
    endtask

    // Full port 5 pops on entry to slot 5 while a same-edge push is refused.
    task automatic test_full_pop_push;
        wait_slot(8'd100);
        for (int i = 0; i < 16; i++) begin
            in_valid[5]      = 1'b1;
            in_new_packet[5] = (i == 0);
            in_data[40 +: 8] = 8'(8'h50 + i);
            @(negedge clk);
        end
        in_valid = '0;
        in_new_packet = '0;
        in_data = '0;
        vectors++;
        if (in_ready[5] !== 1'b0 || err_overflow[5] !== 1'b0) begin
            errors++;
            $display("FAIL full5_pre: ready %b err %b want 0 0",
                     in_ready[5], err_overflow[5]);
        end
        wait_slot(8'd4);
        in_valid[5]      = 1'b1;
        in_new_packet[5] = 1'b1;
        in_data[40 +: 8] = 8'h77;
        @(negedge clk);
        in_valid = '0;
        in_new_packet = '0;
        in_data = '0;
        vectors++;
        if ({slot_out, output_wire, output_new_packet, output_data} !==
            {8'd5, 1'b1, 1'b1, 8'h50}) begin
            errors++;
            $display("FAIL full5_pop: got %0d %b/%b/%h want 5 1/1/50",
                     slot_out, output_wire, output_new_packet, output_data);
        end
        vectors++;
        if (err_overflow[5] !== 1'b1 || in_ready[5] !== 1'b1) begin
            errors++;
            $display("FAIL full5_flags: err %b ready %b want 1 1",
                     err_overflow[5], in_ready[5]);
        end
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            wait_slot(8'd5);
            vectors++;
            if ({output_wire, output_new_packet, output_data} !==
                {1'b1, 1'b0, 8'(8'h50 + k)}) begin
                errors++;
                $display("FAIL full5_drain%0d: got %b/%b/%h want 1/0/%h", k,
                         output_wire, output_new_packet, output_data, 8'(8'h50 + k));
            end
        end
        @(negedge clk);
        wait_slot(8'd5);
        vectors++;
        if (output_wire !== 1'b0) begin
            errors++;
            $display("FAIL full5_rejected: got wire %b data %h want 0",
                     output_wire, output_data);
        end
    endtask

    // Asynchronous reset while ports 2 and 9 still hold data.
    task automatic test_reset_midstream;
        wait_slot(8'd100);
        for (int i = 0; i < 2; i++) begin
            in_valid         = 16'h0204;
            in_new_packet    = (i == 0) ? 16'h0204 : 16'h0;
            in_data[16 +: 8] = 8'(8'h21 + i);
            in_data[72 +: 8] = 8'(8'h91 + i);
            @(negedge clk);
        end
        in_valid = '0;
        in_new_packet = '0;
        in_data = '0;
        wait_slot(8'd2);
        vectors++;
        if ({output_wire, output_new_packet, output_data} !== {1'b1, 1'b1, 8'h21}) begin
            errors++;
            $display("FAIL mid_pre: got %b/%b/%h want 1/1/21",
                     output_wire, output_new_packet, output_data);
        end
        vectors++;
        if (err_overflow !== 16'h0021) begin
            errors++;
            $display("FAIL mid_err_pre: got %h want 0021", err_overflow);
        end
        #1 rst = 1'b0;
        #1;
        vectors++;
        if ({output_wire, output_new_packet, output_data, slot_out} !== 18'h0) begin
            errors++;
            $display("FAIL mid_async: got %b/%b/%h slot %0d want all 0",
                     output_wire, output_new_packet, output_data, slot_out);
        end
        vectors++;
        if (err_overflow !== 16'h0 || in_ready !== 16'hFFFF) begin
            errors++;
            $display("FAIL mid_flags: err %h ready %h want 0000 ffff",
                     err_overflow, in_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 256; c++) begin
            vectors++;
            if ({output_wire, output_new_packet, output_data} !== 10'h0 ||
                slot_out !== 8'(c)) begin
                errors++;
                $display("FAIL mid_after slot %0d: got %0d %b/%b/%h want idle",
                         c, slot_out, output_wire, output_new_packet, output_data);
            end
            @(negedge clk);
        end
    endtask

`ifdef INGRESS_STATS_EN
    // Three packets (five bytes) on port 7, then read the counters.
    task automatic test_stats;
        logic flags [5];
        flags = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        wait_slot(8'd100);
        for (int i = 0; i < 5; i++) begin
            in_valid[7]      = 1'b1;
            in_new_packet[7] = flags[i];
            in_data[56 +: 8] = 8'(8'hC0 + i);
            @(negedge clk);
        end
        in_valid = '0;
        in_new_packet = '0;
        in_data = '0;
        repeat (5 * 256 + 4) @(negedge clk);
        stat_port = 4'd7;
        @(negedge clk);
        vectors++;
        if (stat_pkts !== 16'd3) begin
            errors++;
            $display("FAIL stats_port7: got %0d want 3", stat_pkts);
        end
        stat_port = 4'd6;
        @(negedge clk);
        vectors++;
        if (stat_pkts !== 16'd0) begin
            errors++;
            $display("FAIL stats_port6: got %0d want 0", stat_pkts);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_single_port;
        test_overflow;
        test_all_ports;
        test_full_pop_push;
        test_reset_midstream;
`ifdef INGRESS_STATS_EN
        test_stats;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
